dac_comp_sweep: RTL and testbench

Parametrised successor to the fixed two-counter digital DAC/comparator test block. It generates two first-order pulse-density DAC outputs (P and M sides) from programmable codes. It then runs an automatic threshold search against an external comparator input, either as a linear ramp or as a successive-approximation (SAR) search, and reports the trip code. It sits between the tile pins and the analogue comparator cells: the DAC outputs drive the comparator inputs and the comparator decision comes back on `comp_in`.

---
 rtl/dac_comp_sweep.sv | 201 ++++++++++++++++++++
 tb/tb_dac_comp_sweep.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_comp_sweep.sv
// Dual first-order PDM DAC with automatic comparator threshold search (ramp or SAR).
// Optional macro COMP_MAJORITY_EN: 2-of-3 vote over the last three samples of each step.
module dac_comp_sweep #(
   parameter int unsigned WIDTH  = 6,
   parameter int unsigned SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] code_p,
   input  logic [WIDTH-1:0] code_m,
   input  logic             comp_in,
   output logic             dac_p,
   output logic             dac_m,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             found
);

   localparam int unsigned T_STEP = SETTLE << WIDTH;
   localparam int unsigned CNT_W  = (T_STEP > 1) ? $clog2(T_STEP) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_STEP - 1);
   localparam logic [WIDTH-1:0] CODE_MAX = '1;
   localparam logic [WIDTH-1:0] CODE_MSB = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_p_q, acc_p_d;
   logic [WIDTH-1:0] acc_m_q, acc_m_d;
   logic             dac_p_q, dac_p_d;
   logic             dac_m_q, dac_m_d;
   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] trial_q, trial_d;
   logic [WIDTH-1:0] bit_q, bit_d;
   logic             sar_q, sar_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             found_q, found_d;

   logic [WIDTH-1:0] code_p_src_c;
   logic [WIDTH-1:0] sar_keep_c;
   logic             comp_s;
   logic             decision_c;
   logic             search_req_c;

   assign comp_s       = sync2_q;
   assign code_p_src_c = (state_q == S_RUN) ? trial_q : code_p;
   assign sar_keep_c   = decision_c ? (trial_q & ~bit_q) : trial_q;
   assign search_req_c = start && ((mode == 2'b01) || (mode == 2'b10));

   // PDM accumulators and comparator synchroniser
   always_comb begin
      {dac_p_d, acc_p_d} = {1'b0, acc_p_q} + {1'b0, code_p_src_c};
      {dac_m_d, acc_m_d} = {1'b0, acc_m_q} + {1'b0, code_m};
      sync1_d            = comp_in;
      sync2_d            = sync1_q;
   end

`ifdef COMP_MAJORITY_EN
   logic maj_a_q, maj_a_d;
   logic maj_b_q, maj_b_d;

   // Capture comp_s at counts T_STEP-3 and T_STEP-2 for the 2-of-3 vote
   always_comb begin
      maj_a_d = maj_a_q;
      maj_b_d = maj_b_q;
      if (cnt_q == CNT_LAST - CNT_W'(2)) maj_a_d = comp_s;
      if (cnt_q == CNT_LAST - CNT_W'(1)) maj_b_d = comp_s;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         maj_a_q <= 1'b0;
         maj_b_q <= 1'b0;
      end else begin
         maj_a_q <= maj_a_d;
         maj_b_q <= maj_b_d;
      end
   end

   assign decision_c = (maj_a_q & maj_b_q) | (maj_a_q & comp_s) | (maj_b_q & comp_s);
`else
   assign decision_c = comp_s;
`endif

   // Search sequencer: step timing, trial update and result capture
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      trial_d  = trial_q;
      bit_d    = bit_q;
      sar_d    = sar_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      found_d  = found_q;

      case (state_q)
         S_IDLE: begin
            if (search_req_c) begin
               state_d = S_RUN;
               busy_d  = 1'b1;
               cnt_d   = '0;
               sar_d   = mode[1];
               trial_d = mode[1] ? CODE_MSB : '0;
               bit_d   = CODE_MSB;
            end
         end
         S_RUN: begin
            if (cnt_q != CNT_LAST) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               cnt_d = '0;
               if (sar_q) begin
                  if (bit_q[0]) begin
                     state_d  = S_IDLE;
                     busy_d   = 1'b0;
                     done_d   = 1'b1;
                     result_d = sar_keep_c;
                     found_d  = 1'b1;
                  end else begin
                     trial_d = sar_keep_c | (bit_q >> 1);
                     bit_d   = bit_q >> 1;
                  end
               end else if (decision_c) begin
                  state_d  = S_IDLE;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  result_d = trial_q;
                  found_d  = 1'b1;
               end else if (trial_q == CODE_MAX) begin
                  state_d  = S_IDLE;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  result_d = CODE_MAX;
                  found_d  = 1'b0;
               end else begin
                  trial_d = trial_q + WIDTH'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         acc_p_q  <= '0;
         acc_m_q  <= '0;
         dac_p_q  <= 1'b0;
         dac_m_q  <= 1'b0;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         cnt_q    <= '0;
         trial_q  <= '0;
         bit_q    <= '0;
         sar_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         found_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_p_q  <= acc_p_d;
         acc_m_q  <= acc_m_d;
         dac_p_q  <= dac_p_d;
         dac_m_q  <= dac_m_d;
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         cnt_q    <= cnt_d;
         trial_q  <= trial_d;
         bit_q    <= bit_d;
         sar_q    <= sar_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         found_q  <= found_d;
      end
   end

   assign dac_p  = dac_p_q;
   assign dac_m  = dac_m_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign found  = found_q;

endmodule

// File: tb/tb_dac_comp_sweep.sv
// Bench for dac_comp_sweep (WIDTH=4, SETTLE=2): PDM density, ramp/SAR searches, control and glitch cases.
module tb_dac_comp_sweep;

   localparam int unsigned W     = 4;
   localparam int unsigned S     = 2;
   localparam int          T     = 32;
   localparam int          CODES = 16;
`ifdef COMP_MAJORITY_EN
   localparam bit MAJ = 1'b1;
`else
   localparam bit MAJ = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   mode;
   logic [W-1:0] code_p;
   logic [W-1:0] code_m;
   logic         comp_in;
   logic         dac_p;
   logic         dac_m;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         found;

   int n_cmp = 0;
   int n_err = 0;

   dac_comp_sweep #(.WIDTH(W), .SETTLE(S)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .code_p(code_p), .code_m(code_m), .comp_in(comp_in),
      .dac_p(dac_p), .dac_m(dac_m), .busy(busy), .done(done),
      .result(result), .found(found)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (dac_p !== 1'b0) begin n_err++; $display("FAIL reset_dac_p got %b want 0", dac_p); end
      n_cmp++; if (dac_m !== 1'b0) begin n_err++; $display("FAIL reset_dac_m got %b want 0", dac_m); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
      n_cmp++; if (result !== '0) begin n_err++; $display("FAIL reset_result got %0d want 0", result); end
      n_cmp++; if (found !== 1'b0) begin n_err++; $display("FAIL reset_found got %b want 0", found); end
      rst = 1'b0;
   endtask

   // Pulse start with a non-search mode and require busy/done to stay low
   task automatic test_start_ignored(input logic [1:0] m, input string name);
      bit bad;
      bad = 1'b0;
      @(negedge clk); mode = m; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if ((busy !== 1'b0 || done !== 1'b0) && !bad) begin
            bad = 1'b1; n_err++;
            $display("FAIL %s busy=%b done=%b want 0/0 at cycle %0d", name, busy, done, i);
         end
         @(posedge clk); #1;
      end
      n_cmp++;
   endtask

   // Pulse density: over any 16 consecutive cycles a fixed code yields exactly code ones
   task automatic test_static();
      int np, nm;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         mode   = 2'b00;
         code_p = (i == 0) ? W'(4)  : W'($urandom_range(0, CODES - 1));
         code_m = (i == 0) ? W'(12) : W'($urandom_range(0, CODES - 1));
         @(posedge clk); #1;
         np = 0; nm = 0;
         for (int j = 0; j < CODES; j++) begin
            @(posedge clk); #1;
            if (dac_p) np++;
            if (dac_m) nm++;
         end
         n_cmp++; if (np !== int'(code_p)) begin n_err++; $display("FAIL static_dac_p code=%0d ones=%0d want %0d", code_p, np, code_p); end
         n_cmp++; if (nm !== int'(code_m)) begin n_err++; $display("FAIL static_dac_m code=%0d ones=%0d want %0d", code_m, nm, code_m); end
      end
      test_start_ignored(2'b00, "static_start");
   endtask

   // Run one search; comparator trips when trial > thr, with an optional one-cycle glitch
   task automatic run_search(input bit is_sar, input int thr, input int glitch_step,
                             input int start_pulse_at, input bit flip_mode, input string name);
      int tr [CODES];
      int code, n_steps, exp_res, total, st, off, t;
      bit exp_found, d, bad;
      logic [W-1:0] exp_res_l;

      code = 0; n_steps = 0; exp_res = CODES - 1; exp_found = 1'b0;
      for (int s = 0; s < (is_sar ? int'(W) : CODES); s++) begin
         t = is_sar ? (code | (1 << (int'(W) - 1 - s))) : s;
         d = (t > thr) || (s == glitch_step && !MAJ);
         tr[s] = t;
         n_steps = s + 1;
         if (is_sar) begin
            if (!d) code = t;
         end else if (d) begin
            exp_res = t; exp_found = 1'b1;
            break;
         end
      end
      if (is_sar) begin exp_res = code; exp_found = 1'b1; end
      exp_res_l = W'(exp_res);
      total = n_steps * T;

      @(negedge clk);
      mode = is_sar ? 2'b10 : 2'b01;
      comp_in = (tr[0] > thr);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy_rise got %b want 1", name, busy); end

      bad = 1'b0;
      for (int c = 0; c < total; c++) begin
         st = c / T; off = c % T;
         comp_in = (tr[st] > thr) || (st == glitch_step && off == T - 3);
         start = (c == start_pulse_at);
         if (flip_mode && c == 3) mode = is_sar ? 2'b01 : 2'b10;
         @(posedge clk); #1;
         if (c < total - 1 && (done !== 1'b0 || busy !== 1'b1) && !bad) begin
            bad = 1'b1; n_err++;
            $display("FAIL %s in_run done=%b busy=%b want 0/1 at cycle %0d of %0d", name, done, busy, c + 1, total);
         end
      end
      start = 1'b0; comp_in = 1'b0;
      n_cmp++;
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL %s done_time got %b want 1 at cycle %0d", name, done, total); end
      n_cmp++; if (result !== exp_res_l) begin n_err++; $display("FAIL %s result got %0d want %0d", name, result, exp_res_l); end
      n_cmp++; if (found !== exp_found) begin n_err++; $display("FAIL %s found got %b want %b", name, found, exp_found); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy_end got %b want 0", name, busy); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL %s done_pulse got %b want 0", name, done); end
      n_cmp++; if (result !== exp_res_l) begin n_err++; $display("FAIL %s result_hold got %0d want %0d", name, result, exp_res_l); end
   endtask

   task automatic test_ramp_trip();    run_search(1'b0, 9, -1, -1, 1'b0, "ramp_trip");   endtask
   task automatic test_ramp_no_trip(); run_search(1'b0, 99, -1, -1, 1'b0, "ramp_notrip"); endtask
   task automatic test_sar();          run_search(1'b1, 9, -1, -1, 1'b0, "sar");          endtask

   task automatic test_control();
      run_search(1'b0, 5, -1, 40, 1'b1, "ramp_ctrl");
      run_search(1'b1, 3, -1, 70, 1'b1, "sar_ctrl");
      test_start_ignored(2'b11, "mode11_start");
   endtask

   task automatic test_glitch();
      run_search(1'b0, 99, 3, -1, 1'b0, "glitch");
   endtask

   task automatic test_reset_mid_run();
      bit bad;
      @(negedge clk); mode = 2'b01; comp_in = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (70) @(posedge clk);
      #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_mid done got %b want 0", done); end
      n_cmp++; if (result !== '0) begin n_err++; $display("FAIL rst_mid result got %0d want 0", result); end
      n_cmp++; if (found !== 1'b0) begin n_err++; $display("FAIL rst_mid found got %b want 0", found); end
      n_cmp++; if (dac_p !== 1'b0) begin n_err++; $display("FAIL rst_mid dac_p got %b want 0", dac_p); end
      n_cmp++; if (dac_m !== 1'b0) begin n_err++; $display("FAIL rst_mid dac_m got %b want 0", dac_m); end
      bad = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         if ((busy !== 1'b0 || done !== 1'b0) && !bad) begin
            bad = 1'b1; n_err++;
            $display("FAIL rst_mid_after busy=%b done=%b want 0/0 at cycle %0d", busy, done, i);
         end
      end
      n_cmp++;
   endtask

   task automatic test_random();
      int thr;
      bit is_sar;
      for (int i = 0; i < 4; i++) begin
         thr    = $urandom_range(0, CODES - 1);
         is_sar = 1'($urandom_range(0, 1));
         code_p = W'($urandom_range(0, CODES - 1));
         run_search(is_sar, thr, -1, -1, 1'b0, is_sar ? "rand_sar" : "rand_ramp");
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 2'b00;
      code_p = '0; code_m = '0; comp_in = 1'b0;
      test_reset();
      test_static();
      test_ramp_trip();
      test_ramp_no_trip();
      test_sar();
      test_reset_mid_run();
      test_control();
      test_glitch();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
